// File: rtl/esc_motion_sequencer.sv
// Motion sequencer for the BLDC ESC core: start/stop, alignment, speed-reference
// ramping, direction reversal through a coast brake, stall watchdog and autotune restart.
module esc_motion_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 24,
  parameter int START_PERIOD = 4000,
  parameter int MIN_PERIOD   = 150,
  parameter int RAMP_STEP    = 16,
  parameter int RAMP_DIV     = 1024,
  parameter int ALIGN_CYCLES = 50000,
  parameter int COAST_CYCLES = 100000,
  parameter int STALL_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir_cmd,
  input  logic [DATA_WIDTH-1:0] target_period,
  input  logic [DATA_WIDTH-1:0] period_speed,
  input  logic                  speed_valid,
  input  logic [2:0]            autotune_sel_in,
  input  logic                  clear_fault,
  output logic                  pwm_en,
  output logic [DATA_WIDTH-1:0] period_reference,
  output logic                  tuner_reset,
  output logic [2:0]            autotune_select,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_BRAKE = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam int EW      = DATA_WIDTH + 2;
  localparam int MAX_MAG = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [EW-1:0] STEP_S = EW'(RAMP_STEP);

  function automatic logic [DATA_WIDTH-1:0] clamp_target(input logic [DATA_WIDTH-1:0] t);
    if (t < DATA_WIDTH'(MIN_PERIOD)) return DATA_WIDTH'(MIN_PERIOD);
    if (t > DATA_WIDTH'(MAX_MAG))    return DATA_WIDTH'(MAX_MAG);
    return t;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] signed_ref(input logic [DATA_WIDTH-1:0] mag,
                                                       input logic neg);
    logic signed [DATA_WIDTH-1:0] s;
    s = $signed(mag);
    if (neg) s = -s;
    return $unsigned(s);
  endfunction

  state_t                  state_q, state_d;
  logic                    dir_lat_q, dir_lat_d;
  logic [DATA_WIDTH-1:0]   ref_mag_q, ref_mag_d;
  logic [2:0]              auto_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    ramp_cnt_q, ramp_cnt_d;
  logic [CNT_WIDTH-1:0]    wd_cnt_q, wd_cnt_d;
  logic                    arm_q, arm_d;
  logic                    brake_idle_q, brake_idle_d;
  logic                    tuner_d;
  logic [DATA_WIDTH-1:0]   tgt;
  logic signed [EW-1:0]    diff;
  logic                    wd_expire;
  logic                    drive_d;

  // The measured period itself is consumed by the ESC core; only its update strobe matters here.
  logic unused_period_speed;
  assign unused_period_speed = ^period_speed;

  assign tgt       = clamp_target(target_period);
  assign diff      = $signed({2'b00, tgt}) - $signed({2'b00, ref_mag_q});
  assign wd_expire = !speed_valid && (wd_cnt_q >= CNT_WIDTH'(STALL_CYCLES - 1));
  assign drive_d   = (state_d == ST_ALIGN) || (state_d == ST_RAMP) || (state_d == ST_RUN);
  assign state     = state_q;

  always_comb begin
    state_d      = state_q;
    dir_lat_d    = dir_lat_q;
    ref_mag_d    = ref_mag_q;
    auto_d       = autotune_select;
    cnt_d        = cnt_q;
    ramp_cnt_d   = ramp_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    arm_d        = arm_q;
    brake_idle_d = brake_idle_q;
    tuner_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          dir_lat_d = dir_cmd;
          auto_d    = autotune_sel_in;
          ref_mag_d = DATA_WIDTH'(START_PERIOD);
          arm_d     = 1'b1;
          state_d   = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        if (stop || (dir_cmd != dir_lat_q)) begin
          brake_idle_d = stop;
          cnt_d        = '0;
          state_d      = ST_BRAKE;
        end else if (cnt_q >= CNT_WIDTH'(ALIGN_CYCLES - 1)) begin
          cnt_d      = '0;
          ramp_cnt_d = '0;
          wd_cnt_d   = '0;
          state_d    = ST_RAMP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_RAMP, ST_RUN: begin
        if (wd_expire) begin
          wd_cnt_d = '0;
          state_d  = ST_FAULT;
        end else if (stop || (dir_cmd != dir_lat_q)) begin
          brake_idle_d = stop;
          cnt_d        = '0;
          wd_cnt_d     = '0;
          state_d      = ST_BRAKE;
        end else begin
          wd_cnt_d = speed_valid ? '0 : sat_inc(wd_cnt_q);
          if (state_q == ST_RAMP) begin
            if (ramp_cnt_q >= CNT_WIDTH'(RAMP_DIV - 1)) begin
              ramp_cnt_d = '0;
              if (diff < -STEP_S) begin
                ref_mag_d = ref_mag_q - DATA_WIDTH'(RAMP_STEP);
              end else if (diff > STEP_S) begin
                ref_mag_d = ref_mag_q + DATA_WIDTH'(RAMP_STEP);
              end else begin
                ref_mag_d = tgt;
                wd_cnt_d  = '0;
                state_d   = ST_RUN;
                // Autotune restarts only once per start or reversal, not on every RAMP->RUN hop.
                if (arm_q) begin
                  tuner_d = 1'b1;
                  arm_d   = 1'b0;
                end
              end
            end else begin
              ramp_cnt_d = sat_inc(ramp_cnt_q);
            end
          end else if ((diff > STEP_S) || (diff < -STEP_S)) begin
            ramp_cnt_d = '0;
            wd_cnt_d   = '0;
            state_d    = ST_RAMP;
          end else begin
            ref_mag_d = tgt;
          end
        end
      end

      ST_BRAKE: begin
        if (stop) brake_idle_d = 1'b1;
        if (cnt_q >= CNT_WIDTH'(COAST_CYCLES - 1)) begin
          cnt_d = '0;
          if (brake_idle_q || stop) begin
            state_d = ST_IDLE;
          end else begin
            dir_lat_d = dir_cmd;
            ref_mag_d = DATA_WIDTH'(START_PERIOD);
            arm_d     = 1'b1;
            state_d   = ST_ALIGN;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_FAULT: begin
        if (clear_fault && !start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      dir_lat_q        <= 1'b0;
      ref_mag_q        <= '0;
      cnt_q            <= '0;
      ramp_cnt_q       <= '0;
      wd_cnt_q         <= '0;
      arm_q            <= 1'b0;
      brake_idle_q     <= 1'b0;
      autotune_select  <= '0;
      pwm_en           <= 1'b0;
      period_reference <= '0;
      tuner_reset      <= 1'b0;
      busy             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state_q          <= state_d;
      dir_lat_q        <= dir_lat_d;
      ref_mag_q        <= ref_mag_d;
      cnt_q            <= cnt_d;
      ramp_cnt_q       <= ramp_cnt_d;
      wd_cnt_q         <= wd_cnt_d;
      arm_q            <= arm_d;
      brake_idle_q     <= brake_idle_d;
      autotune_select  <= auto_d;
      pwm_en           <= drive_d;
      period_reference <= drive_d ? signed_ref(ref_mag_d, dir_lat_d) : '0;
      tuner_reset      <= tuner_d;
      busy             <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
      fault            <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_esc_motion_sequencer.sv
// Directed bench for esc_motion_sequencer with shortened timing parameters.
module tb_esc_motion_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_ALIGN = 3'd1, S_RAMP = 3'd2,
                         S_RUN = 3'd3, S_BRAKE = 3'd4, S_FAULT = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0, dir_cmd = 1'b0;
  logic        speed_valid = 1'b0, clear_fault = 1'b0;
  logic [15:0] target_period = 16'd300;
  logic [15:0] period_speed = 16'd1000;
  logic [2:0]  autotune_sel_in = 3'd5;
  logic        pwm_en, tuner_reset, busy, fault;
  logic [15:0] period_reference;
  logic [2:0]  autotune_select, state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_cnt = 0;
  bit sv_en = 1'b0;

  esc_motion_sequencer #(
    .DATA_WIDTH(16), .CNT_WIDTH(24), .START_PERIOD(400), .MIN_PERIOD(150),
    .RAMP_STEP(16), .RAMP_DIV(4), .ALIGN_CYCLES(10), .COAST_CYCLES(8), .STALL_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir_cmd(dir_cmd),
    .target_period(target_period), .period_speed(period_speed), .speed_valid(speed_valid),
    .autotune_sel_in(autotune_sel_in), .clear_fault(clear_fault), .pwm_en(pwm_en),
    .period_reference(period_reference), .tuner_reset(tuner_reset),
    .autotune_select(autotune_select), .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stop;
    bit          dir;
    logic [15:0] tgt;
    logic [2:0]  st;
    int          budget;
    bit          pwm;
    logic [15:0] refv;
    bit          busy;
    int          tr;
  } row_t;

  row_t rows[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tuner_reset) tr_cnt++;
    speed_valid = sv_en && (cyc % 5 == 0);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state !== st && n < budget) begin
      tick();
      n++;
    end
    chk({name, " state"}, state, st);
  endtask

  initial begin
    logic [15:0] exp_ramp[7];
    logic [15:0] last;
    int n, k, ramp_cyc;
    bit seen_align;

    rows[0]  = '{0, 1, 16'd300,   S_BRAKE, 100,  0, 16'h0000, 1, 1};
    rows[1]  = '{0, 1, 16'd300,   S_ALIGN, 100,  1, 16'hFE70, 1, 1};
    rows[2]  = '{0, 1, 16'd300,   S_RUN,   200,  1, 16'hFED4, 1, 2};
    rows[3]  = '{0, 0, 16'd300,   S_BRAKE, 100,  0, 16'h0000, 1, 2};
    rows[4]  = '{0, 0, 16'd300,   S_ALIGN, 100,  1, 16'h0190, 1, 2};
    rows[5]  = '{0, 0, 16'd300,   S_RUN,   200,  1, 16'h012C, 1, 3};
    rows[6]  = '{0, 0, 16'd50,    S_RAMP,  20,   1, 16'h012C, 1, 3};
    rows[7]  = '{0, 0, 16'd50,    S_RUN,   200,  1, 16'h0096, 1, 3};
    rows[8]  = '{0, 0, 16'd40000, S_RAMP,  20,   1, 16'h0096, 1, 3};
    rows[9]  = '{0, 0, 16'd40000, S_RUN,   9000, 1, 16'h7FFF, 1, 3};
    rows[10] = '{1, 0, 16'd40000, S_BRAKE, 20,   0, 16'h0000, 1, 3};
    rows[11] = '{0, 0, 16'd300,   S_IDLE,  100,  0, 16'h0000, 0, 3};
    exp_ramp = '{16'd384, 16'd368, 16'd352, 16'd336, 16'd320, 16'd304, 16'd300};

    // Reset state
    #12;
    chk("rst_state", state, S_IDLE);
    chk("rst_pwm", pwm_en, 0);
    chk("rst_ref", period_reference, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_tuner", tuner_reset, 0);
    chk("rst_auto", autotune_select, 0);
    @(negedge clk);
    reset = 1'b1;

    // Forward start, alignment, ramp 400 -> 300, first RUN entry
    sv_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", state, S_ALIGN);
    chk("start_pwm", pwm_en, 1);
    chk("start_ref", period_reference, 16'd400);
    chk("start_busy", busy, 1);
    chk("start_auto", autotune_select, 3'd5);
    n = 0;
    while (state == S_ALIGN && n < 100) begin
      n++;
      tick();
    end
    chk("align_len", n, 10);
    chk("align_exit", state, S_RAMP);
    chk("ramp_entry_ref", period_reference, 16'd400);
    k = 0;
    n = 0;
    ramp_cyc = 1;
    last = period_reference;
    while (state != S_RUN && n < 200) begin
      tick();
      n++;
      if (state == S_RAMP) ramp_cyc++;
      if (period_reference !== last) begin
        if (k < 7) chk($sformatf("ramp_step%0d", k), period_reference, exp_ramp[k]);
        k++;
        last = period_reference;
      end
    end
    chk("ramp_steps", k, 7);
    chk("ramp_cycles", ramp_cyc, 28);
    chk("run_state", state, S_RUN);
    chk("run_ref", period_reference, 16'd300);
    chk("run_tuner1", tr_cnt, 1);
    repeat (10) tick();
    chk("run_hold_state", state, S_RUN);
    chk("run_tuner_once", tr_cnt, 1);

    // Reversal, clamping and stop sequences
    for (int i = 0; i < 12; i++) begin
      stop = rows[i].stop;
      dir_cmd = rows[i].dir;
      target_period = rows[i].tgt;
      wait_state(rows[i].st, rows[i].budget, $sformatf("row%0d", i));
      chk($sformatf("row%0d pwm", i), pwm_en, rows[i].pwm);
      chk($sformatf("row%0d ref", i), period_reference, rows[i].refv);
      chk($sformatf("row%0d busy", i), busy, rows[i].busy);
      chk($sformatf("row%0d fault", i), fault, 0);
      chk($sformatf("row%0d tuner", i), tr_cnt, rows[i].tr);
    end
    stop = 1'b0;

    // Stall: no speed_valid for STALL_CYCLES in RUN
    target_period = 16'd300;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_RUN, 200, "stall_run");
    sv_en = 1'b0;
    speed_valid = 1'b1;
    tick();
    n = 0;
    while (state == S_RUN && n < 100) begin
      tick();
      n++;
    end
    chk("stall_len", n, 20);
    chk("stall_state", state, S_FAULT);
    chk("stall_fault", fault, 1);
    chk("stall_pwm", pwm_en, 0);
    chk("stall_busy", busy, 0);
    chk("stall_ref", period_reference, 0);
    clear_fault = 1'b1;
    start = 1'b1;
    tick();
    clear_fault = 1'b0;
    start = 1'b0;
    tick();
    chk("clr_with_start", state, S_FAULT);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_state", state, S_IDLE);
    chk("clr_fault", fault, 0);

    // Stop and direction change in the same cycle
    sv_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_RUN, 200, "sd_run");
    stop = 1'b1;
    dir_cmd = 1'b1;
    tick();
    chk("sd_brake", state, S_BRAKE);
    chk("sd_pwm", pwm_en, 0);
    stop = 1'b0;
    n = 0;
    seen_align = 1'b0;
    while (state == S_BRAKE && n < 50) begin
      tick();
      n++;
      if (state == S_ALIGN) seen_align = 1'b1;
    end
    chk("sd_exit_idle", state, S_IDLE);
    chk("sd_no_align", seen_align, 0);
    dir_cmd = 1'b0;

    // speed_valid on the expiry cycle keeps the watchdog from firing
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_RUN, 200, "sv_run");
    sv_en = 1'b0;
    speed_valid = 1'b1;
    tick();
    repeat (19) tick();
    speed_valid = 1'b1;
    tick();
    chk("sv_wins_state", state, S_RUN);
    chk("sv_wins_fault", fault, 0);
    stop = 1'b1;
    wait_state(S_IDLE, 50, "sv_stop");
    stop = 1'b0;

    // Asynchronous reset mid-RAMP, then a reverse start
    sv_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_RAMP, 50, "ar_ramp");
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("ar_state", state, S_IDLE);
    chk("ar_pwm", pwm_en, 0);
    chk("ar_ref", period_reference, 0);
    chk("ar_busy", busy, 0);
    chk("ar_auto", autotune_select, 0);
    tick();
    reset = 1'b1;
    dir_cmd = 1'b1;
    autotune_sel_in = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_restart_state", state, S_ALIGN);
    chk("ar_restart_ref", period_reference, 16'hFE70);
    chk("ar_restart_auto", autotune_select, 3'd3);
    chk("ar_restart_pwm", pwm_en, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esc_motion_sequencer.md
Name: esc_motion_sequencer

Overview:
Sequences the BLDC ESC core. Handles start/stop, direction reversal, speed-reference ramping, stall detection and autotune restart. It drives the ESC's pwm_en, period_reference and tuner_reset from operator commands and monitors the measured encoder period.

Parameters:
DATA_WIDTH, 16, width of periods and references
CNT_WIDTH, 24, width of timing counters
START_PERIOD, 4000, reference magnitude during ALIGN (slow, large period)
MIN_PERIOD, 150, lowest legal reference magnitude (fastest speed)
RAMP_STEP, 16, reference magnitude change per ramp tick
RAMP_DIV, 1024, clk cycles per ramp tick
ALIGN_CYCLES, 50000, ALIGN dwell in clk cycles
COAST_CYCLES, 100000, BRAKE dwell with pwm off
STALL_CYCLES, 200000, max clk cycles between speed_valid pulses in RAMP/RUN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; start request, sampled only in IDLE
stop  in  1  level; stop request
dir_cmd  in  1  0 = forward, 1 = reverse
target_period  in  DATA_WIDTH  unsigned target period magnitude
period_speed  in  DATA_WIDTH  measured period from ESC
speed_valid  in  1  1-cycle pulse when period_speed updates
autotune_sel_in  in  3  autotune mode, latched on start
clear_fault  in  1  1-cycle fault acknowledge
pwm_en  out  1  ESC pwm enable
period_reference  out  DATA_WIDTH  signed reference to ESC
tuner_reset  out  1  1-cycle autotune restart pulse
autotune_select  out  3  latched autotune mode
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  stall fault flag
state  out  3  IDLE=0, ALIGN=1, RAMP=2, RUN=3, BRAKE=4, FAULT=5

Behaviour:
- Reset (reset low, async): state IDLE. pwm_en, tuner_reset, fault and busy are 0. period_reference=0, autotune_select=0. All counters=0. dir_lat=0, ref_mag=0.
- All outputs are registered. A state change becomes visible the cycle after its condition is sampled.
- Target clamp: tgt = MIN_PERIOD if target_period<MIN_PERIOD; tgt = 32767 if target_period>32767; otherwise target_period.
- period_reference = ref_mag when dir_lat=0, and -ref_mag (two's complement, so >32767) when dir_lat=1. It is 0 in IDLE, BRAKE and FAULT.
- IDLE: pwm_en=0. start=1 and stop=0 -> latch dir_lat=dir_cmd and autotune_select=autotune_sel_in, set ref_mag=START_PERIOD, go to ALIGN.
- ALIGN: pwm_en=1 and ref_mag held. After ALIGN_CYCLES cycles -> RAMP. The stall watchdog is inactive here.
- RAMP: a tick occurs every RAMP_DIV cycles. On each tick:
  - ref_mag > tgt+RAMP_STEP -> ref_mag -= RAMP_STEP.
  - ref_mag < tgt-RAMP_STEP -> ref_mag += RAMP_STEP.
  - otherwise ref_mag=tgt and go to RUN.
  - tgt is re-evaluated on every tick.
- RUN: ref_mag tracks tgt only through RAMP. If |tgt-ref_mag| > RAMP_STEP, go back to RAMP; smaller differences load ref_mag=tgt directly. On the first RUN entry after each start, tuner_reset pulses high for exactly 1 cycle. No pulse on later re-entries.
- Direction change: dir_cmd != dir_lat in ALIGN, RAMP or RUN -> BRAKE. At BRAKE exit, dir_lat=dir_cmd, ref_mag=START_PERIOD, go to ALIGN (no IDLE visit). The tuner_reset first-entry flag is re-armed.
- Stop: stop=1 in ALIGN, RAMP or RUN -> BRAKE, with the exit target being IDLE.
- BRAKE: pwm_en=0 for COAST_CYCLES, then exit to the target recorded at entry.
  - stop asserting during a reversal BRAKE changes the exit target to IDLE.
  - A dir_cmd change during a stop BRAKE is ignored.
- Stall watchdog: active in RAMP and RUN. The counter clears on speed_valid and on state entry. When it reaches STALL_CYCLES -> FAULT.
- FAULT: pwm_en=0 and fault=1. Exit to IDLE only on clear_fault=1 with start=0. clear_fault while start=1 is ignored.
- Priority in one cycle: stall fault > stop > direction change > ramp/target logic. speed_valid and watchdog expiry in the same cycle -> speed_valid wins (no fault).
- Counters saturate rather than wrap. A reset mid-operation returns immediately to the reset values above.

Test Plan:
- Start fwd (ALIGN_CYCLES=10, RAMP_DIV=4, RAMP_STEP=16, START_PERIOD=400, target=300, speed_valid every 5 cycles) -> ALIGN for 10 cycles at ref 400; ref falls 384, 368…; RUN with ref=300; one tuner_reset pulse.
- Reverse start, target 300 -> period_reference=0xFED4 in RUN. Toggle dir_cmd -> pwm_en=0 for COAST_CYCLES, then ALIGN with ref 0x0190 (dir fwd) and a second tuner_reset at RUN.
- target_period=50 -> ramps to 150. target_period=40000 -> clamps at 32767.
- Stop speed_valid in RUN (STALL_CYCLES=20) -> FAULT after 20 cycles with fault=1 and pwm_en=0. clear_fault with start=1 is ignored; with start=0 -> IDLE.
- stop and dir change in the same cycle in RUN -> BRAKE then IDLE (no ALIGN). speed_valid coinciding with watchdog expiry -> no fault.
- Assert reset low mid-RAMP -> all outputs 0 asynchronously and state IDLE. Release, then start -> normal ALIGN.
